// File: rtl/power_domain_sequencer_pkg.sv
// power_domain_sequencer_pkg: per-domain state encodings and delay counter width
package power_domain_sequencer_pkg;
    localparam int PD_CNT_W = 16;
    localparam logic [3:0] PD_ON       = 4'd0;
    localparam logic [3:0] PD_ISO      = 4'd1;
    localparam logic [3:0] PD_SAVE     = 4'd2;
    localparam logic [3:0] PD_PWR_DN   = 4'd3;
    localparam logic [3:0] PD_OFF      = 4'd4;
    localparam logic [3:0] PD_WAIT_GNT = 4'd5;
    localparam logic [3:0] PD_PWR_UP   = 4'd6;
    localparam logic [3:0] PD_SETTLE   = 4'd7;
    localparam logic [3:0] PD_RESTORE  = 4'd8;
    localparam logic [3:0] PD_DEISO    = 4'd9;
endpackage

// File: rtl/power_domain_sequencer_fsm.sv
// power_domain_sequencer_fsm: one domain's power sequence FSM; PD_SEQ_RETENTION_EN enables SAVE/RESTORE retention
module power_domain_sequencer_fsm
    import power_domain_sequencer_pkg::*;
#(
    parameter int PWR_DN_DLY = 4,
    parameter int PWR_UP_DLY = 8,
    parameter int PG_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_on,
    input  logic       retain,
    input  logic       pwr_good,
    input  logic       err,
    input  logic       gnt,
    output logic [3:0] state,
    output logic       pwr_en,
    output logic       iso,
    output logic       ret,
    output logic       save,
    output logic       restore,
    output logic       timeout,
    output logic       done
);
`ifdef PD_SEQ_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif
    localparam logic [PD_CNT_W-1:0] DN_LAST = PD_CNT_W'(PWR_DN_DLY - 1);
    localparam logic [PD_CNT_W-1:0] UP_LAST = PD_CNT_W'(PWR_UP_DLY - 1);
    localparam logic [PD_CNT_W-1:0] PG_LAST = PD_CNT_W'(PG_TIMEOUT - 1);
    logic [3:0] state_d;
    logic [PD_CNT_W-1:0] cnt_q, cnt_d;
    logic ret_q, ret_d;
    always_comb begin
        state_d = state;
        cnt_d = cnt_q + 1'b1;
        ret_d = ret_q;
        timeout = 1'b0;
        case (state)
            PD_ON: begin
                state_d = req_on ? PD_ON : PD_ISO;
                ret_d = req_on ? ret_q : RET & retain;
            end
            PD_ISO: begin
                state_d = ret_q ? PD_SAVE : PD_PWR_DN;
                cnt_d = '0;
            end
            PD_SAVE: begin
                state_d = PD_PWR_DN;
                cnt_d = '0;
            end
            PD_PWR_DN: state_d = (cnt_q == DN_LAST) ? PD_OFF : PD_PWR_DN;
            PD_OFF: state_d = (req_on && !err) ? PD_WAIT_GNT : PD_OFF;
            PD_WAIT_GNT: begin
                state_d = gnt ? PD_PWR_UP : PD_WAIT_GNT;
                cnt_d = '0;
            end
            PD_PWR_UP: begin
                timeout = !pwr_good && cnt_q == PG_LAST;
                state_d = pwr_good ? PD_SETTLE : timeout ? PD_PWR_DN : PD_PWR_UP;
                cnt_d = (pwr_good || timeout) ? '0 : cnt_q + 1'b1;
            end
            PD_SETTLE: state_d = (cnt_q != UP_LAST) ? PD_SETTLE : ret_q ? PD_RESTORE : PD_DEISO;
            PD_RESTORE: state_d = PD_DEISO;
            PD_DEISO: begin
                state_d = PD_ON;
                ret_d = 1'b0;
            end
            default: state_d = PD_ON;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= PD_ON;
            cnt_q <= '0;
            ret_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
            ret_q <= ret_d;
        end
    end
    assign pwr_en  = !(state inside {PD_PWR_DN, PD_OFF, PD_WAIT_GNT});
    assign iso     = state != PD_ON;
    assign save    = RET & (state == PD_SAVE);
    assign restore = RET & (state == PD_RESTORE);
    assign ret     = RET & ret_q & !(state inside {PD_ON, PD_ISO, PD_DEISO});
    assign done    = state_d != state && (state_d == PD_ON || state_d == PD_OFF);
endmodule

// File: rtl/power_domain_sequencer.sv
// power_domain_sequencer: rush-limited isolate/switch/settle sequencer for NUM_DOMAINS domains (PD_SEQ_RETENTION_EN adds retention)
module power_domain_sequencer
    import power_domain_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 8,
    parameter int MAX_UP      = 2,
    parameter int PWR_DN_DLY  = 4,
    parameter int PWR_UP_DLY  = 8,
    parameter int PG_TIMEOUT  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] pd_req_on_i,
    input  logic [NUM_DOMAINS-1:0] pd_retain_i,
    input  logic [NUM_DOMAINS-1:0] pwr_good_i,
    input  logic                   err_clr_i,
    output logic [NUM_DOMAINS-1:0] pd_pwr_en_o,
    output logic [NUM_DOMAINS-1:0] pd_iso_o,
    output logic [NUM_DOMAINS-1:0] pd_ret_o,
    output logic [NUM_DOMAINS-1:0] pd_save_o,
    output logic [NUM_DOMAINS-1:0] pd_restore_o,
    output logic [NUM_DOMAINS-1:0] pd_ack_o,
    output logic                   pd_busy_o,
    output logic [NUM_DOMAINS-1:0] timeout_err_o,
    output logic [31:0]            transition_cnt_o
);
    localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
    logic [3:0] st [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] wait_v, up_v, busy_v, done_v, tmo_v, gnt_v, err_q;
    logic [IDX_W-1:0] ptr_q, gnt_idx;
    logic gnt_vld;
    logic [31:0] cnt_q;
    logic [32:0] cnt_sum;
    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        power_domain_sequencer_fsm #(
            .PWR_DN_DLY(PWR_DN_DLY),
            .PWR_UP_DLY(PWR_UP_DLY),
            .PG_TIMEOUT(PG_TIMEOUT)
        ) u_fsm (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_on  (pd_req_on_i[i]),
            .retain  (pd_retain_i[i]),
            .pwr_good(pwr_good_i[i]),
            .err     (err_q[i]),
            .gnt     (gnt_v[i]),
            .state   (st[i]),
            .pwr_en  (pd_pwr_en_o[i]),
            .iso     (pd_iso_o[i]),
            .ret     (pd_ret_o[i]),
            .save    (pd_save_o[i]),
            .restore (pd_restore_o[i]),
            .timeout (tmo_v[i]),
            .done    (done_v[i])
        );
        assign wait_v[i]   = st[i] == PD_WAIT_GNT;
        assign up_v[i]     = st[i] == PD_PWR_UP || st[i] == PD_SETTLE;
        assign busy_v[i]   = !(st[i] == PD_ON || st[i] == PD_OFF);
        assign pd_ack_o[i] = (st[i] == PD_ON && pd_req_on_i[i]) || (st[i] == PD_OFF && !pd_req_on_i[i]);
    end
    always_comb begin
        gnt_idx = ptr_q;
        gnt_vld = 1'b0;
        for (int j = NUM_DOMAINS - 1; j >= 0; j--) begin
            if (wait_v[(int'(ptr_q) + j) % NUM_DOMAINS]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'((int'(ptr_q) + j) % NUM_DOMAINS);
            end
        end
        gnt_vld = gnt_vld && $countones(up_v) < MAX_UP;
    end
    assign gnt_v = gnt_vld ? NUM_DOMAINS'(1) << gnt_idx : '0;
    assign cnt_sum = {1'b0, cnt_q} + 33'($countones(done_v));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            if (gnt_vld) ptr_q <= (int'(gnt_idx) == NUM_DOMAINS - 1) ? '0 : gnt_idx + 1'b1;
            err_q <= (err_q & ~{NUM_DOMAINS{err_clr_i}}) | tmo_v;
            cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
        end
    end
    assign pd_busy_o        = |busy_v;
    assign timeout_err_o    = err_q;
    assign transition_cnt_o = cnt_q;
endmodule

// File: tb/tb_power_domain_sequencer.sv
// tb_power_domain_sequencer: directed scenarios checked every cycle against a phase/offset model of the sequencer
module tb_power_domain_sequencer;
    localparam int N = 8, MAX_UP = 2, DN = 4, UP = 8, PGT = 64;
`ifdef PD_SEQ_RETENTION_EN
    localparam int RET = 1;
`else
    localparam int RET = 0;
`endif
    localparam int P_ON = 0, P_OFF = 1, P_DOWN = 2, P_WAIT = 3, P_POWERING = 4, P_TAIL = 5;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [N-1:0] req = '1, retain = 8'h55, pg = '1;
    logic err_clr = 1'b0;
    logic [N-1:0] pwr_en, iso, ret, save, restore, ack, err;
    logic busy;
    logic [31:0] cnt;
    int checks = 0, errors = 0;
    int seq [N];
    int k [N];
    bit mret [N];
    bit merr [N];
    longint mcnt;
    int mptr;
    always #5 clk_i = ~clk_i;
    power_domain_sequencer #(
        .NUM_DOMAINS(N), .MAX_UP(MAX_UP), .PWR_DN_DLY(DN), .PWR_UP_DLY(UP), .PG_TIMEOUT(PGT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pd_req_on_i(req), .pd_retain_i(retain), .pwr_good_i(pg),
        .err_clr_i(err_clr), .pd_pwr_en_o(pwr_en), .pd_iso_o(iso), .pd_ret_o(ret), .pd_save_o(save),
        .pd_restore_o(restore), .pd_ack_o(ack), .pd_busy_o(busy), .timeout_err_o(err),
        .transition_cnt_o(cnt)
    );
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            seq[i] = P_ON; k[i] = 0; mret[i] = 0; merr[i] = 0;
        end
        mcnt = 0; mptr = 0;
    endtask
    task automatic model_step();
        int slots, g, fin;
        if (rst_i) begin
            model_reset();
            return;
        end
        slots = 0; g = -1; fin = 0;
        for (int i = 0; i < N; i++) slots += (seq[i] == P_POWERING || (seq[i] == P_TAIL && k[i] < UP)) ? 1 : 0;
        if (slots < MAX_UP)
            for (int j = N - 1; j >= 0; j--) if (seq[(mptr + j) % N] == P_WAIT) g = (mptr + j) % N;
        if (g >= 0) mptr = (g + 1) % N;
        for (int i = 0; i < N; i++) begin
            int ck;
            ck = k[i];
            k[i]++;
            merr[i] = merr[i] && !err_clr;
            case (seq[i])
                P_ON: if (!req[i]) begin seq[i] = P_DOWN; k[i] = 0; mret[i] = RET != 0 && retain[i]; end
                P_OFF: if (req[i] && !(k[i] < 0) && !merr_prev(i)) seq[i] = P_WAIT;
                P_DOWN: if (ck == int'(mret[i]) + DN) begin seq[i] = P_OFF; fin++; end
                P_WAIT: if (i == g) begin seq[i] = P_POWERING; k[i] = 0; end
                P_POWERING: begin
                    if (pg[i]) begin seq[i] = P_TAIL; k[i] = 0; end
                    else if (ck == PGT - 1) begin merr[i] = 1; seq[i] = P_DOWN; k[i] = 1 + int'(mret[i]); end
                end
                P_TAIL: if (ck == UP + int'(mret[i])) begin seq[i] = P_ON; mret[i] = 0; fin++; end
                default: ;
            endcase
        end
        mcnt = (mcnt + fin > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mcnt + fin;
        err_prev_latch();
    endtask
    bit err_snap [N];
    function automatic bit merr_prev(int i);
        return err_snap[i];
    endfunction
    task automatic err_prev_latch();
        for (int i = 0; i < N; i++) err_snap[i] = merr[i];
    endtask
    task automatic compare_all();
        logic [N-1:0] e_en, e_iso, e_ret, e_sv, e_rs, e_ack, e_err;
        logic e_busy;
        e_busy = 0;
        for (int i = 0; i < N; i++) begin
            e_en[i] = 1; e_iso[i] = 1; e_ret[i] = mret[i]; e_sv[i] = 0; e_rs[i] = 0; e_ack[i] = 0;
            e_err[i] = merr[i];
            case (seq[i])
                P_ON: begin e_iso[i] = 0; e_ret[i] = 0; e_ack[i] = req[i]; end
                P_OFF: begin e_en[i] = 0; e_ack[i] = !req[i]; end
                P_DOWN: begin
                    e_en[i] = k[i] < 1 + int'(mret[i]);
                    e_ret[i] = mret[i] && k[i] >= 1;
                    e_sv[i] = mret[i] && k[i] == 1;
                end
                P_WAIT: e_en[i] = 0;
                P_TAIL: begin
                    e_ret[i] = mret[i] && k[i] <= UP;
                    e_rs[i] = mret[i] && k[i] == UP;
                end
                default: ;
            endcase
            if (seq[i] != P_ON && seq[i] != P_OFF) e_busy = 1;
        end
        check("pwr_en", pwr_en, e_en);
        check("iso", iso, e_iso);
        check("ret", ret, e_ret);
        check("save", save, e_sv);
        check("restore", restore, e_rs);
        check("ack", ack, e_ack);
        check("busy", busy, e_busy);
        check("err", err, e_err);
        check("cnt", cnt, mcnt[31:0]);
    endtask
    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask
    initial begin
        int rise [4];
        longint c0;
        model_reset();
        err_prev_latch();
        repeat (2) cycle();
        rst_i = 0;
        cycle();
        check("t1_pwr_en", pwr_en, 8'hFF);
        check("t1_iso", iso, 8'h00);
        check("t1_ack", ack, 8'hFF);
        check("t1_busy", busy, 1'b0);
        check("t1_cnt", cnt, 32'd0);
        req[0] = 0;
        for (int m = 0; m < 8; m++) begin
            cycle();
            if (m == RET) check("t2_pwr_en_hi", pwr_en[0], 1'b1);
            if (m == 1 + RET) check("t2_pwr_en_lo", pwr_en[0], 1'b0);
            if (m == 1) check("t2_save", save[0], RET[0]);
            if (m == 4 + RET) check("t2_ack_lo", ack[0], 1'b0);
            if (m == 5 + RET) begin
                check("t2_ack_hi", ack[0], 1'b1);
                check("t2_cnt", cnt, 32'd1);
            end
        end
        req[3:1] = 0;
        repeat (16) cycle();
        req[3:0] = 4'hF;
        for (int d = 0; d < 4; d++) rise[d] = -1;
        for (int m = 0; m < 40; m++) begin
            cycle();
            for (int d = 0; d < 4; d++) if (rise[d] < 0 && pwr_en[d]) rise[d] = m;
        end
        check("t3_gap01", rise[1] - rise[0], 1);
        check("t3_gap12", rise[2] - rise[1], 9);
        check("t3_gap23", rise[3] - rise[2], 1);
        check("t3_ack", ack[3:0], 4'hF);
        req[3] = 0;
        repeat (16) cycle();
        pg[3] = 0;
        req[3] = 1;
        repeat (65) cycle();
        err_clr = 1;
        cycle();
        err_clr = 0;
        check("t4_set_wins", err[3], 1'b1);
        repeat (8) cycle();
        check("t4_off", pwr_en[3], 1'b0);
        check("t4_ack", ack[3], 1'b0);
        check("t4_err", err, 8'h08);
        pg[3] = 1;
        err_clr = 1;
        cycle();
        err_clr = 0;
        check("t4_clr", err[3], 1'b0);
        repeat (30) cycle();
        check("t4_back_on", ack[3], 1'b1);
        req[1] = 0;
        repeat (2) cycle();
        c0 = mcnt;
        req[1] = 1;
        repeat (4) cycle();
        check("t5_off_ack", ack[1], 1'b0);
        check("t5_cnt_off", cnt, c0[31:0] + 32'd1);
        repeat (20) cycle();
        check("t5_on_ack", ack[1], 1'b1);
        check("t5_cnt_on", cnt, c0[31:0] + 32'd2);
        req[2] = 0;
        repeat (16) cycle();
        req[2] = 1;
        repeat (6) cycle();
        check("t6_busy", busy, 1'b1);
        rst_i = 1;
        cycle();
        rst_i = 0;
        check("t6_rst_pwr_en", pwr_en, 8'hFF);
        check("t6_rst_iso", iso, 8'h00);
        check("t6_rst_ack", ack, 8'hFF);
        check("t6_rst_cnt", cnt, 32'd0);
        check("t6_rst_busy", busy, 1'b0);
        force dut.cnt_q = 32'hFFFF_FFFE;
        mcnt = 64'hFFFF_FFFE;
        cycle();
        release dut.cnt_q;
        check("t6_preset", cnt, 32'hFFFF_FFFE);
        req[7:5] = 3'b000;
        repeat (12) cycle();
        check("t6_sat", cnt, 32'hFFFF_FFFF);
        req[7:5] = 3'b111;
        repeat (30) cycle();
        check("t6_sat_hold", cnt, 32'hFFFF_FFFF);
        check("t6_final_ack", ack, 8'hFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
